mux_pipe_reg: RTL and testbench
===============================

Name: mux_pipe_reg

Overview:
- Parametrised successor to the single-bit posedge D flip-flop and the 2:1 mux primitive.
- Selects one of CHANNELS input words, then carries it through a DEPTH-stage register pipeline with valid/ready flow control, bubble collapsing and synchronous flush.
- Sits between producer and consumer blocks wherever a registered, back-pressurable channel selector is needed.

Parameters:
- WIDTH, 8: data word width in bits (>=1).
- CHANNELS, 2: number of input channels (>=2).
- DEPTH, 2: number of pipeline stages (>=1).
- RESET_VAL, 0: value loaded into every stage data register on reset. Applied as a WIDTH-bit value.

Ports:
- clk  input  1: clock; all state updates on its posedge.
- rst  input  1: reset, synchronous, active-high.
- sel  input  SELW=$clog2(CHANNELS): channel select, sampled on the input transfer cycle.
- in_data  input  CHANNELS*WIDTH: packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  1: producer has a word.
- in_ready  output  1: pipe can accept a word this cycle.
- flush  input  1: discard all contents.
- out_data  output  WIDTH: data of the last stage.
- out_valid  output  1: last stage holds a word.
- out_ready  input  1: consumer accepts a word.
- occupancy  output  $clog2(DEPTH+1): number of valid stages.

Behaviour:
- Reset (rst=1 at posedge):
  - All stage valid bits go to 0 and all stage data registers go to RESET_VAL.
  - out_valid=0, out_data=RESET_VAL, occupancy=0.
  - in_ready is 0 during any cycle with rst=1.
  - rst has priority over flush and over any transfer.
  - Reset mid-stream drops all words.
- Input transfer: occurs when in_valid & in_ready at a posedge. Stage 0 captures in_data[sel*WIDTH +: WIDTH].
- Out-of-range sel (sel>=CHANNELS, only possible when CHANNELS is not a power of 2): stage 0 captures RESET_VAL and the transfer still counts.
- Stage advance: stage i (i<DEPTH-1) moves into stage i+1 when stage i+1 is empty or stage i+1 is itself advancing. The last stage advances when out_ready=1.
- Bubble collapsing: an empty stage never blocks upstream stages.
- Input readiness: in_ready = !rst & !flush & (stage 0 empty | stage 0 advancing). This is combinational from out_ready through the stage valid chain. There is no combinational path from in_valid to in_ready.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+DEPTH-1 into an empty pipe with out_ready held 1, i.e. DEPTH cycles of register delay from in_data to out_data.
- Throughput: one word per cycle when unstalled.
- Ordering: words are strictly FIFO; no word is duplicated or lost except by flush or rst.
- Stall: out_data and out_valid hold stable while out_valid & !out_ready.
- Full: with all DEPTH stages valid and out_ready=0, in_ready=0. With all stages valid and out_ready=1, in_ready=1 (simultaneous push and pop).
- Data registers of empty stages may load anything; bench checks out_data only when out_valid=1.
- Flush (flush=1 at posedge, rst=0): all valid bits clear at that edge. Any concurrent input is not accepted because in_ready=0. A word popped in the same cycle (out_valid & out_ready) counts as delivered.
- Occupancy: equals the popcount of the stage valid bits, registered alongside them. Range 0..DEPTH, never wraps.

Optional Feature:
- Macro: MUX_PIPE_REG_STALL_CNT_EN.
- Defined: adds port stall_cnt (output, 16 bits), a counter of cycles with out_valid & !out_ready.
  - Saturates at 16'hFFFF and does not wrap.
  - Cleared only by rst; flush does not clear it.
- Undefined: the port and the counter are absent, and there is no other behavioural difference.

Test Plan:
1. WIDTH=8, CHANNELS=4, DEPTH=3, out_ready=1: push 8'hA5 on ch2 (sel=2) -> out_valid=1 and out_data=8'hA5 exactly 3 edges later; occupancy reads 1 throughout.
2. Back-to-back stream of 10 words 0..9 with sel cycling 0..3, consumer accepting every cycle -> 10 outputs in order, one per cycle, in_ready constantly 1.
3. out_ready=0, push until in_ready=0 -> exactly 3 words accepted, occupancy=3. Then raise out_ready for 1 cycle with in_valid=1 -> one pop plus one push in the same cycle, occupancy stays 3.
4. Pipe holds 2 words, assert flush with in_valid=1 -> in_ready=0 that cycle; next cycle occupancy=0 and out_valid=0; the flushed words never appear.
5. CHANNELS=3, sel=3 with in_valid=1 -> the captured word emerges equal to RESET_VAL. Then assert rst mid-stream with 2 words in flight -> next cycle out_valid=0 and out_data=RESET_VAL.
6. With MUX_PIPE_REG_STALL_CNT_EN defined: hold out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5. Then flush -> stall_cnt remains 5. Then rst -> stall_cnt=0.

Source files
------------

// File: rtl/mux_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pipe_reg
// Description : Selects one of CHANNELS input words and carries it through a
//               DEPTH-stage register pipeline with valid/ready flow control,
//               bubble collapsing and synchronous flush.
//
// Ports       : clk        - clock, all state updates on posedge
//               rst        - synchronous active-high reset
//               sel        - channel select, sampled on the input transfer
//               in_data    - packed channels, channel k at [k*WIDTH +: WIDTH]
//               in_valid   - producer has a word
//               in_ready   - pipe can accept a word this cycle
//               flush      - discard all contents at the next edge
//               out_data   - data of the last stage
//               out_valid  - last stage holds a word
//               out_ready  - consumer accepts a word
//               occupancy  - number of valid stages
//               stall_cnt  - (MUX_PIPE_REG_STALL_CNT_EN only) saturating
//                            count of cycles with out_valid & !out_ready
//
// Option      : define MUX_PIPE_REG_STALL_CNT_EN to add the stall counter.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mux_pipe_reg #(
    parameter int  WIDTH     = 8,
    parameter int  CHANNELS  = 2,
    parameter int  DEPTH     = 2,
    parameter int  RESET_VAL = 0,
    localparam int SELW      = $clog2(CHANNELS),
    localparam int OCCW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OCCW-1:0]           occupancy
`ifdef MUX_PIPE_REG_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam logic [WIDTH-1:0] c_rst_val = WIDTH'(RESET_VAL);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [OCCW-1:0]  r_occ;

    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_valid_nxt;
    logic [OCCW-1:0]  w_occ_nxt;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_stage0_free;
    logic             w_push;

    // Channel mux. Select codes with no matching channel fall through to the
    // reset value, so a non-power-of-two channel count never reads past the
    // packed input vector.
    always_comb begin : p_sel_mux
        w_sel_data = c_rst_val;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SELW'(k)) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Advance chain, walked from the output back toward stage 0. w_go means
    // "the stage below may move into the stage currently being visited": it
    // starts as out_ready for the last stage and becomes true for the stage
    // above whenever this stage is empty (bubble) or is itself moving on.
    always_comb begin : p_advance
        logic w_go;
        w_go  = out_ready;
        w_adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_adv[i] = r_valid[i] & w_go;
            w_go     = ~r_valid[i] | w_go;
        end
        w_stage0_free = w_go;
    end

    assign in_ready = ~rst & ~flush & w_stage0_free;
    assign w_push   = in_valid & in_ready;

    // Next valid bits: a stage is full next cycle if something moves in, or
    // it is full now and nothing moves out.
    always_comb begin : p_valid_nxt
        w_valid_nxt = r_valid;
        for (int i = DEPTH - 1; i > 0; i--) begin
            w_valid_nxt[i] = w_adv[i-1] | (r_valid[i] & ~w_adv[i]);
        end
        w_valid_nxt[0] = w_push | (r_valid[0] & ~w_adv[0]);
    end

    always_comb begin : p_occ_nxt
        w_occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ_nxt = w_occ_nxt + OCCW'(w_valid_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin : p_pipe
        if (rst) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= c_rst_val;
            end
        end else if (flush) begin
            // Data registers are left as they are; only the valid bits matter.
            r_valid <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
            if (w_push) begin
                r_data[0] <= w_sel_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_adv[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign out_data  = r_data[DEPTH-1];
    assign out_valid = r_valid[DEPTH-1];
    assign occupancy = r_occ;

`ifdef MUX_PIPE_REG_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating stall counter; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin : p_stall_cnt
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_valid[DEPTH-1] && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    // Stall counter not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_pipe_reg
// Description : Directed self-checking bench for mux_pipe_reg. One instance
//               with four channels, one with three channels (out-of-range
//               select), both DEPTH=3, WIDTH=8, RESET_VAL=8'h5A. Define
//               MUX_PIPE_REG_STALL_CNT_EN to also exercise the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_pipe_reg;

    localparam int        c_width = 8;
    localparam int        c_depth = 3;
    localparam logic [7:0] c_rv   = 8'h5A;

    logic        clk;
    logic        rst;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic        in_valid;
    logic        flush;
    logic        out_ready;

    logic        w_in_ready4;
    logic [7:0]  w_out_data4;
    logic        w_out_valid4;
    logic [1:0]  w_occ4;
    logic        w_in_ready3;
    logic [7:0]  w_out_data3;
    logic        w_out_valid3;
    logic [1:0]  w_occ3;
`ifdef MUX_PIPE_REG_STALL_CNT_EN
    logic [15:0] w_stall4;
    logic [15:0] w_stall3;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int acc;

    mux_pipe_reg #(
        .WIDTH(c_width), .CHANNELS(4), .DEPTH(c_depth), .RESET_VAL(32'h5A)
    ) u_dut4 (
        .clk(clk), .rst(rst), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(w_in_ready4), .flush(flush),
        .out_data(w_out_data4), .out_valid(w_out_valid4),
        .out_ready(out_ready), .occupancy(w_occ4)
`ifdef MUX_PIPE_REG_STALL_CNT_EN
        , .stall_cnt(w_stall4)
`endif
    );

    mux_pipe_reg #(
        .WIDTH(c_width), .CHANNELS(3), .DEPTH(c_depth), .RESET_VAL(32'h5A)
    ) u_dut3 (
        .clk(clk), .rst(rst), .sel(sel), .in_data(in_data[23:0]),
        .in_valid(in_valid), .in_ready(w_in_ready3), .flush(flush),
        .out_data(w_out_data3), .out_valid(w_out_valid3),
        .out_ready(out_ready), .occupancy(w_occ3)
`ifdef MUX_PIPE_REG_STALL_CNT_EN
        , .stall_cnt(w_stall3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; sel = '0; in_data = '0; in_valid = 1'b0;
        flush = 1'b0; out_ready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_in_ready", w_in_ready4, 0);
        check("rst_out_valid", w_out_valid4, 0);
        check("rst_out_data", w_out_data4, c_rv);
        check("rst_occ", w_occ4, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", w_in_ready4, 1);

        // ---------------- 1: single word latency ----------------
        out_ready = 1'b1;
        sel = 2'd2;
        in_data = 32'h11_A5_22_44;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_occ_e1", w_occ4, 1);
        check("t1_ov_e1", w_out_valid4, 0);
        tick();
        check("t1_occ_e2", w_occ4, 1);
        check("t1_ov_e2", w_out_valid4, 0);
        tick();
        check("t1_occ_e3", w_occ4, 1);
        check("t1_ov_e3", w_out_valid4, 1);
        check("t1_data", w_out_data4, 8'hA5);
        tick();
        check("t1_ov_drained", w_out_valid4, 0);
        check("t1_occ_drained", w_occ4, 0);

        // ---------------- 2: back-to-back stream ----------------
        for (int i = 0; i < 10; i++) begin
            sel = 2'(i % 4);
            in_data = 32'hFFFF_FFFF;
            in_data[(i % 4)*8 +: 8] = 8'(i);
            in_valid = 1'b1;
            #1;
            check("t2_in_ready", w_in_ready4, 1);
            tick();
            check("t2_ov", w_out_valid4, (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 2) check("t2_data", w_out_data4, 32'(i - 2));
        end
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t2_tail_ov", w_out_valid4, 1);
            check("t2_tail_data", w_out_data4, 32'(8 + k));
        end
        tick();
        check("t2_empty", w_out_valid4, 0);

        // ---------------- 3: fill, then push+pop ----------------
        out_ready = 1'b0;
        sel = 2'd0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            in_data = {24'h0, 8'(8'h30 + acc)};
            in_valid = 1'b1;
            #1;
            if (w_in_ready4) acc++;
            tick();
        end
        check("t3_accepted", acc, 3);
        check("t3_occ_full", w_occ4, 3);
        check("t3_in_ready_full", w_in_ready4, 0);
        check("t3_head", w_out_data4, 8'h30);
        out_ready = 1'b1;
        in_data = {24'h0, 8'h40};
        #1;
        check("t3_in_ready_pushpop", w_in_ready4, 1);
        tick();
        in_valid = 1'b0;
        check("t3_occ_pushpop", w_occ4, 3);
        check("t3_head2", w_out_data4, 8'h31);
        tick();
        check("t3_drain1", w_out_data4, 8'h32);
        tick();
        check("t3_drain2", w_out_data4, 8'h40);
        tick();
        check("t3_drained", w_out_valid4, 0);

        // ---------------- 4: flush ----------------
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = {24'h0, 8'h50};
        tick();
        in_data = {24'h0, 8'h51};
        tick();
        check("t4_occ2", w_occ4, 2);
        flush = 1'b1;
        in_data = {24'h0, 8'h52};
        #1;
        check("t4_in_ready_flush", w_in_ready4, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t4_occ0", w_occ4, 0);
        check("t4_ov0", w_out_valid4, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4_no_ghost", w_out_valid4, 0);
        end

        // ---------------- 5: out-of-range select, reset mid-stream ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sel = 2'd3;
        in_data = 32'h11_22_33_44;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("t5_ov_e2", w_out_valid3, 0);
        tick();
        check("t5_ov_e3", w_out_valid3, 1);
        check("t5_oor_data", w_out_data3, c_rv);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        sel = 2'd0;
        in_data = 32'h00_00_00_61;
        tick();
        sel = 2'd1;
        in_data = 32'h00_00_62_00;
        tick();
        in_valid = 1'b0;
        tick();
        check("t5_occ2", w_occ3, 2);
        check("t5_head", w_out_data3, 8'h61);
        rst = 1'b1;
        #1;
        check("t5_in_ready_rst", w_in_ready3, 0);
        tick();
        check("t5_rst_ov", w_out_valid3, 0);
        check("t5_rst_data", w_out_data3, c_rv);
        check("t5_rst_occ", w_occ3, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_no_ghost", w_out_valid3, 0);
        end

`ifdef MUX_PIPE_REG_STALL_CNT_EN
        // ---------------- 6: stall counter ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_cnt_rst", w_stall4, 0);
        out_ready = 1'b0;
        sel = 2'd0;
        in_data = 32'h00_00_00_77;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("t6_ov", w_out_valid4, 1);
        check("t6_cnt0", w_stall4, 0);
        for (int k = 0; k < 5; k++) tick();
        check("t6_cnt5", w_stall4, 5);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_cnt_flush", w_stall4, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_cnt_cleared", w_stall4, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
